// File: rtl/busca_sar4bits_pkg.sv
// Shared definitions for the successive-approximation search engine:
// FSM state encodings, default operand width and the comparator flag check.
package busca_sar4bits_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    localparam logic [1:0] ST_OCIOSO = 2'd0;
    localparam logic [1:0] ST_TESTA  = 2'd1;
    localparam logic [1:0] ST_FIM    = 2'd2;

    // A trustworthy comparator verdict has exactly one flag set.
    function automatic logic flags_one_hot(input logic maior, input logic menor,
                                           input logic igual);
        logic ok;
        case ({maior, menor, igual})
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/busca_sar4bits.sv
// busca_sar4bits: SAR search engine driving the X operand of an external
// magnitude comparator and resolving the unknown Y one bit per clock, MSB first.
// Optional macro SAR_EARLY_EXIT_EN: an igual verdict ends the search at once.
module busca_sar4bits
    import busca_sar4bits_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inicio,
    input  logic             maior,
    input  logic             menor,
    input  logic             igual,
    output logic [WIDTH-1:0] tentativa,
    output logic [WIDTH-1:0] resultado,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] tent_q, tent_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             erro_q, erro_d;
    logic [WIDTH-1:0] trial;
    logic             flags_ok, keep, hit;

    // Next-state logic: one comparator decision per TESTA cycle.
    always_comb begin
        state_d  = state_q;
        tent_d   = tent_q;
        res_d    = res_q;
        idx_d    = idx_q;
        erro_d   = erro_q;
        flags_ok = flags_one_hot(maior, menor, igual);
        // Bad flags fall back to the maior verdict (bit cleared).
        // igual keeps the bit, which is what menor does.
        keep     = flags_ok && !maior;
        hit      = 1'b0;
`ifdef SAR_EARLY_EXIT_EN
        hit      = flags_ok && igual;
`endif
        trial        = tent_q;
        trial[idx_q] = keep;

        case (state_q)
            ST_OCIOSO: begin
                if (inicio) begin
                    tent_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    idx_d   = IW'(WIDTH-1);
                    erro_d  = 1'b0;
                    state_d = ST_TESTA;
                end
            end
            ST_TESTA: begin
                if (!flags_ok) erro_d = 1'b1;
                if (hit) begin
                    res_d   = tent_q;
                    state_d = ST_FIM;
                end else if (idx_q != '0) begin
                    trial[idx_q - IW'(1)] = 1'b1;
                    tent_d  = trial;
                    idx_d   = idx_q - IW'(1);
                end else begin
                    tent_d  = trial;
                    res_d   = trial;
                    state_d = ST_FIM;
                end
            end
            ST_FIM:  state_d = ST_OCIOSO;
            default: state_d = ST_OCIOSO;
        endcase
    end

    // State and datapath registers; reset aborts any search in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OCIOSO;
            tent_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tent_q  <= tent_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            erro_q  <= erro_d;
        end
    end

    assign tentativa = tent_q;
    assign resultado = res_q;
    assign ocupado   = (state_q == ST_TESTA) || (state_q == ST_FIM);
    assign pronto    = (state_q == ST_FIM);
    assign erro      = erro_q;

endmodule

// File: tb/tb_busca_sar4bits.sv
// Directed bench for busca_sar4bits: a behavioural 4-bit comparator closes the
// loop against a stimulus Y; expected trial sequences are hand-computed tables.
module tb_busca_sar4bits;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inicio = 1'b0;
    logic       maior, menor, igual;
    logic [3:0] tentativa, resultado;
    logic       ocupado, pronto, erro;

    logic [3:0] y_stim = 4'd0;
    logic       force0 = 1'b0;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Comparator X=tentativa vs Y=y_stim, with an override that zeroes all flags.
    assign maior = !force0 && (tentativa >  y_stim);
    assign menor = !force0 && (tentativa <  y_stim);
    assign igual = !force0 && (tentativa == y_stim);

    busca_sar4bits #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inicio    (inicio),
        .maior     (maior),
        .menor     (menor),
        .igual     (igual),
        .tentativa (tentativa),
        .resultado (resultado),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .erro      (erro)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One search: inicio pulsed for a cycle, cyc counts edges since the inicio
    // cycle (cyc=1 is the first TESTA cycle). Optional re-pulse / flag override.
    task automatic search(input string nm, input logic [3:0] y,
                          input logic [3:0] t0, input logic [3:0] t1,
                          input logic [3:0] t2, input logic [3:0] t3,
                          input int exp_lat, input int exp_erro,
                          input int repulse_at, input int force_at);
        logic [3:0] tr [4];
        int cyc;
        int extra;
        tr[0] = t0; tr[1] = t1; tr[2] = t2; tr[3] = t3;
        y_stim = y;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        cyc = 1;
        chk({nm, " ocupado_start"}, ocupado, 1);
        chk({nm, " erro_cleared"}, erro, 0);
        while (!pronto && cyc < 20) begin
            if (cyc <= 4) chk($sformatf("%s trial%0d", nm, cyc), tentativa, tr[cyc-1]);
            inicio = (cyc == repulse_at);
            force0 = (cyc == force_at);
            @(negedge clk);
            cyc++;
        end
        inicio = 1'b0;
        force0 = 1'b0;
        chk({nm, " latency"}, cyc, exp_lat);
        chk({nm, " resultado"}, resultado, y);
        chk({nm, " erro_at_pronto"}, erro, exp_erro);
        @(negedge clk);
        chk({nm, " pronto_one_cycle"}, pronto, 0);
        chk({nm, " ocupado_after"}, ocupado, 0);
        chk({nm, " erro_sticky"}, erro, exp_erro);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (pronto || ocupado) extra++;
        end
        chk({nm, " no_extra_search"}, extra, 0);
        chk({nm, " resultado_held"}, resultado, y);
    endtask

    int lat8;
    int spurious;

    initial begin
`ifdef SAR_EARLY_EXIT_EN
        lat8 = 2;
`else
        lat8 = 5;
`endif
        // Reset state
        #12;
        chk("rst tentativa", tentativa, 0);
        chk("rst resultado", resultado, 0);
        chk("rst ocupado", ocupado, 0);
        chk("rst pronto", pronto, 0);
        chk("rst erro", erro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        search("y5",  4'd5,  4'd8, 4'd4,  4'd6,  4'd5,  5, 0, 0, 0);
        search("y0",  4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  5, 0, 0, 0);
        search("y15", 4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 5, 0, 0, 0);
        search("y8",  4'd8,  4'd8, 4'd12, 4'd10, 4'd9,  lat8, 0, 0, 0);
        // inicio re-pulsed while busy is ignored
        search("y3rp", 4'd3, 4'd8, 4'd4,  4'd2,  4'd3,  5, 0, 2, 0);
        search("y9",  4'd9,  4'd8, 4'd12, 4'd10, 4'd9,  5, 0, 0, 0);

        // Asynchronous reset mid-search
        y_stim = 4'd6;
        @(negedge clk);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst tentativa", tentativa, 0);
        chk("arst resultado", resultado, 0);
        chk("arst ocupado", ocupado, 0);
        chk("arst pronto", pronto, 0);
        chk("arst erro", erro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(negedge clk);
            if (pronto || ocupado) spurious++;
        end
        chk("arst no_pronto", spurious, 0);
        search("arst_y9", 4'd9, 4'd8, 4'd12, 4'd10, 4'd9, 5, 0, 0, 0);

        // Flags zeroed in the first TESTA cycle: erro set and sticky
        search("flags0", 4'd5, 4'd8, 4'd4, 4'd6, 4'd5, 5, 1, 0, 1);
        // Next accepted inicio clears erro (checked at cyc=1 inside the task)
        search("after_err", 4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 5, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
